// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Protocol bytes and FSM state type shared by the UART frame logic.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        EXEC   = 3'd4,
        RDWAIT = 3'd5,
        RESP   = 3'd6
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_frame_ctrl_if
// Brief     : Byte-in, register-bus and response-byte signals of the frame
//             controller. master = controller side, slave = environment side.
// Revision  : 1.0  initial release
// ============================================================================
interface uart_frame_ctrl_if;

    logic [7:0] rx_dat;
    logic       rx_rdy;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_dat;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rd_dat;
    logic [7:0] tx_dat;
    logic       tx_vld;
    logic       tx_rdy;
    logic [7:0] err_cnt;

    modport master (
        input  rx_dat, rx_rdy, reg_rd_dat, tx_rdy,
        output reg_addr, reg_wr_dat, reg_wr_en, reg_rd_en, tx_dat, tx_vld, err_cnt
    );

    modport slave (
        output rx_dat, rx_rdy, reg_rd_dat, tx_rdy,
        input  reg_addr, reg_wr_dat, reg_wr_en, reg_rd_en, tx_dat, tx_vld, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/uart_byte_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_timer
// Brief    : Inter-byte idle counter; o_expire fires on the TIMEOUT_CYC-th
//            consecutive idle cycle while i_run is high.
// Revision : 1.0  initial release
// ============================================================================
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = 43200,
    parameter int TO_WIDTH    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);

    localparam logic [TO_WIDTH-1:0] c_LAST_CNT = TO_WIDTH'(TIMEOUT_CYC - 1);
    localparam logic [TO_WIDTH-1:0] c_ONE      = TO_WIDTH'(1);

    logic [TO_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_run || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // A byte in the same cycle always beats expiry.
    assign o_expire = i_run && !i_clr && (r_cnt == c_LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Brief    : Sequences SYNC/CMD/DATA/CHK byte frames into register strobes and
//            answers each frame with one ACK, NAK or read-data byte.
// Revision : 1.0  initial release
// ============================================================================
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 43200,
    parameter int TO_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_frame_ctrl_if.master bus
);

    state_t     r_state,   w_state_nxt;
    logic [6:0] r_addr,    w_addr_nxt;
    logic       r_wr_flag, w_wr_flag_nxt;
    logic [7:0] r_wr_dat,  w_wr_dat_nxt;
    logic       r_wr_en,   w_wr_en_nxt;
    logic       r_rd_en,   w_rd_en_nxt;
    logic [7:0] r_tx_dat,  w_tx_dat_nxt;
    logic       r_tx_vld,  w_tx_vld_nxt;
    logic [7:0] r_err_cnt, w_err_cnt_nxt;
    logic       w_err_inc;
    logic       w_in_frame;
    logic       w_expire;
    logic [7:0] w_cmd_byte;

    assign w_in_frame = (r_state == CMD) || (r_state == DATA) || (r_state == CHK);
    assign w_cmd_byte = {r_wr_flag, r_addr};

    uart_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_WIDTH    (TO_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_in_frame),
        .i_clr    (bus.rx_rdy),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wr_flag_nxt = r_wr_flag;
        w_wr_dat_nxt  = r_wr_dat;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_tx_dat_nxt  = r_tx_dat;
        w_tx_vld_nxt  = r_tx_vld;
        w_err_inc     = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.rx_rdy && (bus.rx_dat == SYNC_BYTE)) begin
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (bus.rx_rdy) begin
                    w_wr_flag_nxt = bus.rx_dat[7];
                    w_addr_nxt    = bus.rx_dat[6:0];
                    w_state_nxt   = DATA;
                end else if (w_expire) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (bus.rx_rdy) begin
                    w_wr_dat_nxt = bus.rx_dat;
                    w_state_nxt  = CHK;
                end else if (w_expire) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            CHK: begin
                if (bus.rx_rdy) begin
                    if (bus.rx_dat == (w_cmd_byte ^ r_wr_dat)) begin
                        w_wr_en_nxt = r_wr_flag;
                        w_rd_en_nxt = !r_wr_flag;
                        w_state_nxt = EXEC;
                    end else begin
                        w_tx_dat_nxt = NAK_BYTE;
                        w_tx_vld_nxt = 1'b1;
                        w_err_inc    = 1'b1;
                        w_state_nxt  = RESP;
                    end
                end else if (w_expire) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            EXEC: begin
                w_err_inc = bus.rx_rdy;
                if (r_wr_flag) begin
                    w_tx_dat_nxt = ACK_BYTE;
                    w_tx_vld_nxt = 1'b1;
                    w_state_nxt  = RESP;
                end else begin
                    w_state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                // Read data is valid the cycle after the read strobe.
                w_err_inc    = bus.rx_rdy;
                w_tx_dat_nxt = bus.reg_rd_dat;
                w_tx_vld_nxt = 1'b1;
                w_state_nxt  = RESP;
            end
            RESP: begin
                w_err_inc = bus.rx_rdy;
                if (r_tx_vld && bus.tx_rdy) begin
                    w_tx_vld_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_err_cnt_nxt = w_err_inc ? sat_inc8(r_err_cnt) : r_err_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wr_flag <= 1'b0;
            r_wr_dat  <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_tx_dat  <= '0;
            r_tx_vld  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_flag <= w_wr_flag_nxt;
            r_wr_dat  <= w_wr_dat_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_tx_dat  <= w_tx_dat_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign bus.reg_addr   = r_addr;
    assign bus.reg_wr_dat = r_wr_dat;
    assign bus.reg_wr_en  = r_wr_en;
    assign bus.reg_rd_en  = r_rd_en;
    assign bus.tx_dat     = r_tx_dat;
    assign bus.tx_vld     = r_tx_vld;
    assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Brief    : Directed and randomized frames against a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_frame_ctrl;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_ctrl_if bus ();

    uart_frame_ctrl #(
        .TIMEOUT_CYC (TO),
        .TO_WIDTH    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // External register file: unwritten locations return a fixed pattern.
    logic [7:0] slave_regs [128];
    bit         slave_wr   [128];

    function automatic logic [7:0] dflt(input logic [6:0] a);
        return {a, 1'b0} ^ 8'h7E;
    endfunction

    always @(posedge clk) begin
        if (bus.reg_wr_en) begin
            slave_regs[bus.reg_addr] <= bus.reg_wr_dat;
            slave_wr[bus.reg_addr]   <= 1'b1;
        end
        if (bus.reg_rd_en) begin
            bus.reg_rd_dat <= slave_wr[bus.reg_addr] ? slave_regs[bus.reg_addr] : dflt(bus.reg_addr);
        end
    end

    // Observers, sampled mid-cycle
    logic [7:0] tx_q [$];
    int         tx_cyc_q [$];
    int         wr_pulses = 0;
    int         rd_pulses = 0;
    int         both_high = 0;
    int         stab_viol = 0;
    logic       hold      = 1'b0;
    logic [7:0] held_dat  = '0;

    always @(negedge clk) begin
        if (bus.reg_wr_en) wr_pulses++;
        if (bus.reg_rd_en) rd_pulses++;
        if (bus.reg_wr_en && bus.reg_rd_en) both_high++;
        if (hold && !(bus.tx_vld && (bus.tx_dat == held_dat))) stab_viol++;
        hold     = bus.tx_vld && !bus.tx_rdy && !rst;
        held_dat = bus.tx_dat;
        if (bus.tx_vld && bus.tx_rdy && !rst) begin
            tx_q.push_back(bus.tx_dat);
            tx_cyc_q.push_back(cyc);
        end
    end

    // Frame-level reference state
    logic [7:0] model_regs [128];
    bit         model_wr   [128];
    logic [7:0] exp_err = '0;

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return model_wr[a] ? model_regs[a] : dflt(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_dat = b;
        bus.rx_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  32'(bus.reg_addr),   32'h0);
        check({tag, "_wdat"},  32'(bus.reg_wr_dat), 32'h0);
        check({tag, "_wren"},  32'(bus.reg_wr_en),  32'h0);
        check({tag, "_rden"},  32'(bus.reg_rd_en),  32'h0);
        check({tag, "_txdat"}, 32'(bus.tx_dat),     32'h0);
        check({tag, "_txvld"}, 32'(bus.tx_vld),     32'h0);
        check({tag, "_err"},   32'(bus.err_cnt),    32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_err = '0;
    endtask

    task automatic wait_tx(input int tx0, input int limit);
        int n = 0;
        while (tx_q.size() == tx0 && n < limit) begin
            idle(1);
            n++;
        end
    endtask

    // Full frame with response wait; expected outcome derived from frame rules.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] chk,
                             input int rdy_delay, input int gap);
        int wr0 = wr_pulses;
        int rd0 = rd_pulses;
        int tx0 = tx_q.size();
        int t_chk;
        bit good = (chk == (cmd ^ dat));
        logic [7:0] exp_b = !good ? 8'h15 : (cmd[7] ? 8'h06 : model_rd(cmd[6:0]));
        int exp_lat = !good ? 1 : (cmd[7] ? 2 : 3);

        bus.tx_rdy = (rdy_delay == 0);
        send_byte(8'hA5); idle(gap);
        send_byte(cmd);   idle(gap);
        send_byte(dat);   idle(gap);
        t_chk = cyc;
        send_byte(chk);
        if (rdy_delay > 0) begin
            idle(rdy_delay);
            bus.tx_rdy = 1'b1;
        end
        wait_tx(tx0, 30);

        if (good && cmd[7]) begin
            model_regs[cmd[6:0]] = dat;
            model_wr[cmd[6:0]]   = 1'b1;
        end
        if (!good && exp_err != 8'hFF) exp_err = exp_err + 8'd1;

        check("tx_count", 32'(tx_q.size() - tx0), 32'd1);
        if (tx_q.size() > tx0) begin
            check("tx_byte", 32'(tx_q[tx0]), 32'(exp_b));
            if (rdy_delay == 0) check("tx_latency", 32'(tx_cyc_q[tx0] - t_chk), 32'(exp_lat));
        end
        check("wr_pulses", 32'(wr_pulses - wr0), 32'(good && cmd[7]));
        check("rd_pulses", 32'(rd_pulses - rd0), 32'(good && !cmd[7]));
        check("err_cnt",   32'(bus.err_cnt), 32'(exp_err));
        check("reg_addr",  32'(bus.reg_addr), 32'(cmd[6:0]));
        check("reg_wr_dat", 32'(bus.reg_wr_dat), 32'(dat));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, d, k;
        int tx0;
        int wr0;

        bus.rx_dat = '0;
        bus.rx_rdy = 1'b0;
        bus.tx_rdy = 1'b1;
        for (int i = 0; i < 128; i++) begin
            model_regs[i] = '0;
            model_wr[i]   = 1'b0;
        end
        idle(3);
        rst = 1'b0;
        check_reset_outputs("por");

        // Directed write, read, bad checksum
        run_frame(8'h85, 8'h3C, 8'hB9, 0, 0);
        check("wr_ack", 32'(tx_q[tx_q.size()-1]), 32'h06);
        run_frame(8'h12, 8'h00, 8'h12, 0, 0);
        check("rd_5A", 32'(tx_q[tx_q.size()-1]), 32'h5A);
        run_frame(8'h85, 8'h3C, 8'h00, 0, 0);
        check("nak_err", 32'(bus.err_cnt), 32'h01);

        // SYNC value inside a frame is ordinary data
        run_frame(8'hA5, 8'hA5, 8'h00, 0, 2);
        run_frame(8'h25, 8'h00, 8'h25, 0, 0);

        // Randomized frames with gaps and backpressure
        for (int i = 0; i < 40; i++) begin
            c = 8'($urandom);
            d = 8'($urandom);
            k = ($urandom_range(0, 3) != 0) ? (c ^ d) : (c ^ d ^ 8'($urandom_range(1, 255)));
            run_frame(c, d, k, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                      $urandom_range(0, TO / 4));
        end

        // Partial frame abandoned by timeout, then a good frame
        do_reset();
        tx0 = tx_q.size();
        wr0 = wr_pulses;
        send_byte(8'hA5);
        send_byte(8'h85);
        idle(TO + 5);
        check("to_err", 32'(bus.err_cnt), 32'h01);
        check("to_no_tx", 32'(tx_q.size() - tx0), 32'd0);
        check("to_no_wr", 32'(wr_pulses - wr0), 32'd0);
        exp_err = 8'h01;
        run_frame(8'h85, 8'h3C, 8'hB9, 0, 0);

        // Backpressure with a byte injected during the response
        do_reset();
        tx0 = tx_q.size();
        bus.tx_rdy = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h85);
        send_byte(8'h3C);
        send_byte(8'hB9);
        idle(3);
        send_byte(8'h42);
        idle(46);
        check("bp_vld", 32'(bus.tx_vld), 32'h1);
        check("bp_dat", 32'(bus.tx_dat), 32'h06);
        check("bp_err", 32'(bus.err_cnt), 32'h01);
        check("bp_no_tx", 32'(tx_q.size() - tx0), 32'd0);
        check("bp_stable", 32'(stab_viol), 32'd0);
        bus.tx_rdy = 1'b1;
        wait_tx(tx0, 10);
        idle(2);
        check("bp_one_tx", 32'(tx_q.size() - tx0), 32'd1);
        if (tx_q.size() > tx0) check("bp_ack", 32'(tx_q[tx0]), 32'h06);
        model_regs[7'h05] = 8'h3C;
        model_wr[7'h05]   = 1'b1;

        // Reset while a response is pending
        bus.tx_rdy = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h8A);
        send_byte(8'h77);
        send_byte(8'hFD);
        idle(3);
        check("rr_vld_before", 32'(bus.tx_vld), 32'h1);
        rst = 1'b1;
        idle(1);
        check_reset_outputs("rst_resp");
        rst = 1'b0;
        exp_err = '0;
        bus.tx_rdy = 1'b1;
        model_regs[7'h0A] = 8'h77;
        model_wr[7'h0A]   = 1'b1;
        run_frame(8'h0A, 8'h00, 8'h0A, 0, 0);

        // Noise in IDLE, then error-counter saturation
        do_reset();
        tx0 = tx_q.size();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h11);
        idle(5);
        check("noise_err", 32'(bus.err_cnt), 32'h00);
        check("noise_no_tx", 32'(tx_q.size() - tx0), 32'd0);
        for (int i = 0; i < 300; i++) begin
            c = 8'($urandom);
            d = 8'($urandom);
            run_frame(c, d, c ^ d ^ 8'($urandom_range(1, 255)), 0, 0);
        end
        check("sat_err", 32'(bus.err_cnt), 32'hFF);

        check("strobe_exclusive", 32'(both_high), 32'd0);
        check("tx_stable_all", 32'(stab_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Command-frame controller that sits downstream of `uart_rx` and upstream of a `uart_tx`-style byte transmitter. It sequences received bytes into fixed 4-byte command frames and validates each frame's checksum. Valid frames become single-cycle register-bus write or read strobes. Every frame is answered with exactly one response byte: ACK, NAK, or read data.

## Interface
Parameters:
- `TIMEOUT_CYC`, 43200: idle clocks allowed between bytes of one frame before the frame is abandoned.
- `TO_WIDTH`, 16: width of the inter-byte timeout counter; must hold `TIMEOUT_CYC`.

Ports:
- `clk`  in  1  system clock, 25 MHz, shared with `uart_rx`.
- `rst`  in  1  synchronous reset, active-high.
- `rx_dat`  in  8  received byte, valid when `rx_rdy` is high.
- `rx_rdy`  in  1  one-cycle pulse per received byte.
- `reg_addr`  out  7  register address.
- `reg_wr_dat`  out  8  register write data.
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_rd_en`  out  1  one-cycle read strobe.
- `reg_rd_dat`  in  8  read data, valid the cycle after `reg_rd_en`.
- `tx_dat`  out  8  response byte.
- `tx_vld`  out  1  response valid; held until accepted.
- `tx_rdy`  in  1  transmitter ready; a byte transfers on `tx_vld & tx_rdy`.
- `err_cnt`  out  8  saturating count of frame errors.

## Operation
Frame format, in arrival order:
- SYNC = 8'hA5.
- CMD: bit7 is 1 for write, 0 for read; bits 6:0 are the address.
- DATA: ignored for reads but still required.
- CHK = CMD ^ DATA.

States and transitions:
- IDLE: on `rx_rdy` with `rx_dat == 8'hA5`, go to CMD. Any other byte is discarded silently; `err_cnt` is not incremented.
- CMD: on `rx_rdy`, latch `reg_addr` and the write flag, then go to DATA.
- DATA: on `rx_rdy`, latch `reg_wr_dat`, then go to CHK.
- CHK: on `rx_rdy`, compare against CMD^DATA.
  - Match: go to EXEC.
  - Mismatch: load `tx_dat` = 8'h15 (NAK), increment `err_cnt`, go to RESP.
- EXEC (one cycle): pulse `reg_wr_en` or `reg_rd_en`.
  - Write: load `tx_dat` = 8'h06 (ACK), go to RESP.
  - Read: go to RDWAIT.
- RDWAIT (one cycle): `tx_dat <= reg_rd_dat`, go to RESP.
- RESP: `tx_vld` = 1. On `tx_vld & tx_rdy`, drop `tx_vld` and go to IDLE.

Inter-byte timeout:
- In CMD, DATA and CHK, a counter clears on every `rx_rdy` and increments otherwise.
- On reaching `TIMEOUT_CYC`: go to IDLE, increment `err_cnt`, send no response.

Boundary conditions:
- `rx_rdy` during EXEC, RDWAIT or RESP: byte dropped and `err_cnt` incremented, with no other effect. The host must wait for the response before sending the next frame.
- `err_cnt` saturates at 8'hFF.
- Timeout and `rx_rdy` in the same cycle: `rx_rdy` wins.
- `reg_wr_en` and `reg_rd_en` are never high together.
- A 8'hA5 byte arriving in CMD, DATA or CHK is treated as ordinary data; there is no resynchronisation.

## Timing
- All outputs are registered.
- Reset values: `reg_addr` = 0, `reg_wr_dat` = 0, `reg_wr_en` = 0, `reg_rd_en` = 0, `tx_dat` = 0, `tx_vld` = 0, `err_cnt` = 0. State goes to IDLE and the timeout counter clears.
- Reset takes priority over everything. It aborts any frame or pending response; an un-accepted `tx_vld` drops the following cycle.
- Notation: CHK's `rx_rdy` is at cycle t.
  - Write: `reg_wr_en` high at t+1. `tx_vld` = 1 with ACK from t+2.
  - Read: `reg_rd_en` high at t+1, `reg_rd_dat` sampled at t+2, `tx_vld` from t+3.
  - Bad checksum: NAK with `tx_vld` from t+1.
- `reg_addr` and `reg_wr_dat` stay stable from the CMD/DATA latch until the next frame's CMD/DATA byte.
- `tx_dat` is stable while `tx_vld` is high.
- If `tx_rdy` is already high when `tx_vld` rises, the transfer completes in that cycle, and the state is IDLE the next cycle.

## Structure
- Shared package `uart_pkg` holds:
  - constants `SYNC_BYTE` = 8'hA5, `ACK_BYTE` = 8'h06, `NAK_BYTE` = 8'h15;
  - the state enum {IDLE, CMD, DATA, CHK, EXEC, RDWAIT, RESP}.
- One sub-module, `uart_byte_timer`, holds the clear/increment/expire timeout counter, parameterised by `TIMEOUT_CYC` and `TO_WIDTH`.
- Everything else stays in one FSM module. Target size is about 200 lines.

## Test plan
- Write frame A5,85,3C,B9 with `tx_rdy` = 1: one `reg_wr_en` pulse with `reg_addr` = 7'h05 and `reg_wr_dat` = 8'h3C, then exactly one transmitted byte 8'h06.
- Read frame A5,12,00,12 with the register model returning 8'h5A: one `reg_rd_en` pulse with `reg_addr` = 7'h12, then transmitted byte 8'h5A at t+3.
- Bad checksum A5,85,3C,00: no strobes, transmitted byte 8'h15, `err_cnt` = 1.
- Timeout case:
  - Stimulus: send A5,85, then stay idle for `TIMEOUT_CYC` cycles, then send a full valid write frame.
  - Required response: `err_cnt` = 1 and no response to the partial frame; the second frame is ACKed normally.
- Backpressure and reset:
  - Stimulus: hold `tx_rdy` = 0 for 50 cycles after a write frame and inject `rx_rdy` once during RESP; in a separate run, assert `rst` during RESP.
  - Required response, first run: `tx_vld` and `tx_dat` stable throughout, `err_cnt` = 1, one ACK after `tx_rdy` rises.
  - Required response, second run: all outputs at reset values the following cycle.
- Noise and saturation:
  - Stimulus: send the bytes 00,FF,11 in IDLE, then 300 bad-checksum frames.
  - Required response: the noise bytes cause no responses and leave `err_cnt` at 0; `err_cnt` saturates at 8'hFF.
